// File: rtl/dmem_sram_ctrl.sv
// dmem_sram_ctrl: data-memory controller for the load/store stage, backed by an internal 32-bit word array.
// Latency: a request accepted in cycle T returns mem_ready_o in cycle T+1+WAIT_CYCLES.
// Backpressure: one access in flight; requests are only accepted in IDLE and the core stalls until mem_ready_o.
// Ports:
//   clk, reset_n       clock and synchronous active-low reset
//   mem_req_i          access request (sampled in IDLE only)
//   mem_addr_i         byte address; only the bits covering the array are used, so addresses wrap
//   mem_byte_en_i      size: 00 byte, 01 halfword, 10 reserved (treated as word), 11 word
//   mem_wr_i           1 = store, 0 = load
//   mem_wr_data_i      right-aligned store data
//   mem_rd_data_o      right-aligned load data, held until the next load response
//   mem_ready_o        one-cycle completion pulse
//   mem_err_o          misaligned-access flag, valid with mem_ready_o
module dmem_sram_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic [1:0]  mem_byte_en_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_wr_data_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam int         IW      = $clog2(DEPTH_WORDS);
  localparam int         AW      = IW + 2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept;
  logic          misalign;
  logic [IW-1:0] idx_d;
  logic [IW-1:0] idx_q;
  logic [31:0]   word_rd;
  logic [31:0]   word_sh;
  logic [31:0]   load_val;
  logic [31:0]   lane_mask;
  logic [31:0]   merged;
  logic          do_write;
  logic          unused_addr_hi;

  // Address bits above the array are deliberately dropped (wrap-around).
  assign unused_addr_hi = ^mem_addr_i[31:AW];

  // ---------------------------------------------------------------------------
  // FSM: next state and wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          accept  = 1'b1;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_LD != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch. The _d view is used for the response computation so that a
  // zero-wait access can respond on the very edge that accepts it.
  // ---------------------------------------------------------------------------
  assign addr_d  = accept ? mem_addr_i[AW-1:0] : addr_q;
  assign size_d  = accept ? mem_byte_en_i      : size_q;
  assign wr_d    = accept ? mem_wr_i           : wr_q;
  assign wdata_d = accept ? mem_wr_data_i      : wdata_q;

  assign idx_d   = addr_d[AW-1:2];
  assign idx_q   = addr_q[AW-1:2];

  always_comb begin
    misalign = 1'b0;
    case (size_d)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr_d[0];
      default: misalign = (addr_d[1:0] != 2'b00);
    endcase
  end

  // Load path: shift the addressed lane down to bit 0, then zero the rest.
  assign word_rd = mem_q[idx_d];

  always_comb begin
    word_sh  = word_rd >> {addr_d[1:0], 3'b000};
    load_val = word_rd;
    case (size_d)
      2'b00:   load_val = {24'd0, word_sh[7:0]};
      2'b01:   load_val = {16'd0, word_sh[15:0]};
      default: load_val = word_rd;
    endcase
  end

  // Store path: lane mask over the latched address; for aligned halfwords and
  // words the same byte shift places the data correctly.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00:   lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      2'b01:   lane_mask = 32'h0000_FFFF << {addr_q[1:0], 3'b000};
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    merged = (mem_q[idx_q] & ~lane_mask) | ((wdata_q << {addr_q[1:0], 3'b000}) & lane_mask);
  end

  // In RESP no new request can be accepted, so misalign reflects the latched access.
  assign do_write = (state_q == S_RESP) && wr_q && !misalign;

  // ---------------------------------------------------------------------------
  // Registered outputs, loaded on the edge that enters RESP
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d   = (state_d == S_RESP);
    err_d     = ready_d && misalign;
    rd_data_d = rd_data_q;
    if (ready_d && misalign) begin
      rd_data_d = 32'd0;
    end else if (ready_d && !wr_d) begin
      rd_data_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // The array is never cleared; a reset on the RESP edge cancels a pending store.
  always_ff @(posedge clk) begin
    if (reset_n && do_write) begin
      mem_q[idx_q] <= merged;
    end
  end

  assign mem_rd_data_o = rd_data_q;
  assign mem_ready_o   = ready_q;
  assign mem_err_o     = err_q;

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// tb_dmem_sram_ctrl: checks two controller instances (1024 words / 1 wait state, 64 words / 0 wait states)
// against directed cases and a byte-lane reference model driven with random accesses.
module tb_dmem_sram_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        req   [2];
  logic [31:0] addr  [2];
  logic [1:0]  be    [2];
  logic        wr    [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  int          n_cmp = 0;
  int          n_bad = 0;

  int          depth   [2] = '{1024, 64};
  int          lat_exp [2] = '{2, 1};
  logic [31:0] ref_mem [2][1024];
  logic [31:0] last_rd [2];

  dmem_sram_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset_n(rst_n[0]), .mem_req_i(req[0]), .mem_addr_i(addr[0]),
    .mem_byte_en_i(be[0]), .mem_wr_i(wr[0]), .mem_wr_data_i(wdat[0]),
    .mem_rd_data_o(rdata[0]), .mem_ready_o(ready[0]), .mem_err_o(err[0])
  );

  dmem_sram_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(rst_n[1]), .mem_req_i(req[1]), .mem_addr_i(addr[1]),
    .mem_byte_en_i(be[1]), .mem_wr_i(wr[1]), .mem_wr_data_i(wdat[1]),
    .mem_rd_data_o(rdata[1]), .mem_ready_o(ready[1]), .mem_err_o(err[1])
  );

  // ---------------- reference model ----------------
  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return (a[1:0] != 2'b00);
  endfunction

  function automatic int ref_nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] r;
    int nb, lane;
    r    = 32'd0;
    nb   = ref_nbytes(sz);
    lane = (nb == 4) ? 0 : int'(a[1:0]);
    for (int k = 0; k < nb; k++) r[8*k +: 8] = w[8*(lane+k) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_insert(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz,
                                             input logic [31:0] d);
    logic [31:0] r;
    int nb, lane;
    r    = w;
    nb   = ref_nbytes(sz);
    lane = (nb == 4) ? 0 : int'(a[1:0]);
    for (int k = 0; k < nb; k++) r[8*(lane+k) +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // ---------------- drivers ----------------
  // One access: lat counts cycles from the accept edge to the cycle where ready is seen;
  // quiet is ready|err in the cycle after the response (must be 0).
  task automatic do_access(input int d, input logic [31:0] a, input logic [1:0] sz, input logic w,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat, output logic quiet);
    @(negedge clk);
    req[d] = 1'b1; addr[d] = a; be[d] = sz; wr[d] = w; wdat[d] = wd;
    @(posedge clk); #1;
    // Scramble the inputs: the latched request must govern the access.
    req[d] = 1'b0; addr[d] = $urandom; be[d] = 2'($urandom); wr[d] = 1'($urandom); wdat[d] = $urandom;
    lat = 1;
    while (ready[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata[d];
    er = err[d];
    @(posedge clk); #1;
    quiet = ready[d] | err[d];
  endtask

  task automatic do_reset(input int d);
    @(negedge clk); rst_n[d] = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n[d] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; addr[d] = 32'd0; be[d] = 2'b00; wr[d] = 1'b0; wdat[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (ready[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 0", d, ready[d]); end
      n_cmp++; if (err[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
      n_cmp++; if (rdata[d] !== 32'd0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata[d]); end
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] rd; logic er, q; int lat;
    do_access(0, 32'h100, 2'b11, 1'b1, 32'hDEADBEEF, rd, er, lat, q);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL st_word_lat: got %0d want 2", lat); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL st_word_err: got %b want 0", er); end
    n_cmp++; if (q !== 1'b0) begin n_bad++; $display("FAIL st_word_pulse: ready/err after resp %b want 0", q); end
    do_access(0, 32'h100, 2'b11, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ld_word_lat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_word_data: got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ld_word_err: got %b want 0", er); end
    do_access(0, 32'h102, 2'b00, 1'b1, 32'h00000055, rd, er, lat, q);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_keeps_rdata: got %h want deadbeef", rd); end
    do_access(0, 32'h100, 2'b11, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (rd !== 32'hDE55BEEF) begin n_bad++; $display("FAIL byte_merge: got %h want de55beef", rd); end
    do_access(0, 32'h103, 2'b00, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (rd !== 32'h000000DE) begin n_bad++; $display("FAIL ld_byte3: got %h want 000000de", rd); end
    do_access(0, 32'h101, 2'b01, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL ld_half_mis_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL ld_half_mis_data: got %h want 0", rd); end
    do_access(0, 32'h101, 2'b01, 1'b1, 32'h0000FFFF, rd, er, lat, q);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL st_half_mis_err: got %b want 1", er); end
    do_access(0, 32'h100, 2'b10, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (rd !== 32'hDE55BEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL mis_store_nowrite: got %h err %b want de55beef err 0", rd, er); end
    do_access(0, 32'h1000, 2'b11, 1'b1, 32'h12345678, rd, er, lat, q);
    do_access(0, 32'h0000, 2'b11, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL addr_wrap: got %h want 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, q; int lat;
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 32'h20; be[1] = 2'b11; wr[1] = 1'b1; wdat[1] = 32'hCAFEF00D;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (ready[1] !== 1'((i % 2) == 1)) begin
        n_bad++; $display("FAIL b2b_ready cycle %0d: got %b want %b", i, ready[1], (i % 2) == 1); end
    end
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    do_access(1, 32'h20, 2'b11, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_data: got %h want cafef00d", rd); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w0_lat: got %0d want 1", lat); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er, q, seen; int lat;
    // Abort during WAIT on the one-wait-state instance.
    do_access(0, 32'h200, 2'b11, 1'b1, 32'hAAAA5555, rd, er, lat, q);
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 32'h200; be[0] = 2'b11; wr[0] = 1'b1; wdat[0] = 32'h11111111;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk); rst_n[0] = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rdata[0] !== 32'd0) begin n_bad++; $display("FAIL abort_rdata_clr: got %h want 0", rdata[0]); end
    @(negedge clk); rst_n[0] = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (ready[0] === 1'b1) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_wait_ready: got %b want 0", seen); end
    do_access(0, 32'h200, 2'b11, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (rd !== 32'hAAAA5555) begin n_bad++; $display("FAIL abort_wait_data: got %h want aaaa5555", rd); end
    // Abort during RESP on the zero-wait instance.
    do_access(1, 32'h8, 2'b11, 1'b1, 32'h13572468, rd, er, lat, q);
    do_access(1, 32'h8, 2'b11, 1'b0, 32'h0, rd, er, lat, q);
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 32'h8; be[1] = 2'b11; wr[1] = 1'b1; wdat[1] = 32'h99999999;
    @(posedge clk); #1;
    req[1] = 1'b0;
    n_cmp++; if (ready[1] !== 1'b1) begin n_bad++; $display("FAIL abort_resp_ready: got %b want 1", ready[1]); end
    @(negedge clk); rst_n[1] = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ready[1] !== 1'b0 || rdata[1] !== 32'd0) begin
      n_bad++; $display("FAIL abort_resp_clr: ready %b rdata %h want 0 0", ready[1], rdata[1]); end
    @(negedge clk); rst_n[1] = 1'b1;
    do_access(1, 32'h8, 2'b11, 1'b0, 32'h0, rd, er, lat, q);
    n_cmp++; if (rd !== 32'h13572468) begin n_bad++; $display("FAIL abort_resp_data: got %h want 13572468", rd); end
  endtask

  task automatic test_random(input int d);
    logic [31:0] a, wd, rd, exp_rd; logic [1:0] sz; logic w, er, q, exp_err; int lat, idx;
    do_reset(d);
    last_rd[d] = 32'd0;
    for (int k = 0; k < 16; k++) begin
      wd = $urandom;
      do_access(d, 32'((16 + k) * 4), 2'b11, 1'b1, wd, rd, er, lat, q);
      ref_mem[d][16 + k] = wd;
    end
    for (int n = 0; n < 120; n++) begin
      a  = 32'(($urandom_range(0, 15) + 16) * 4 + $urandom_range(0, 3)) + $urandom * 32'(depth[d] * 4);
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      idx = int'((a >> 2) % 32'(depth[d]));
      exp_err = ref_misaligned(a, sz);
      if (exp_err) last_rd[d] = 32'd0;
      else if (!w) last_rd[d] = ref_extract(ref_mem[d][idx], a, sz);
      else ref_mem[d][idx] = ref_insert(ref_mem[d][idx], a, sz, wd);
      exp_rd = last_rd[d];
      do_access(d, a, sz, w, wd, rd, er, lat, q);
      n_cmp++; if (lat !== lat_exp[d]) begin
        n_bad++; $display("FAIL rnd%0d_lat op %0d: got %0d want %0d", d, n, lat, lat_exp[d]); end
      n_cmp++; if (er !== exp_err) begin
        n_bad++; $display("FAIL rnd%0d_err op %0d a=%h sz=%0d: got %b want %b", d, n, a, sz, er, exp_err); end
      n_cmp++; if (rd !== exp_rd) begin
        n_bad++; $display("FAIL rnd%0d_data op %0d a=%h sz=%0d wr=%b: got %h want %h", d, n, a, sz, w, rd, exp_rd); end
      n_cmp++; if (q !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_pulse op %0d: ready/err after resp %b want 0", d, n, q); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_sram_ctrl.md
DMEM_SRAM_CTRL -- requirements
Module: dmem_sram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal array (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra access wait states (legal range 0..15).
REQ-003 SHALL use one clock and a synchronous, active-low reset; clk and reset_n are the clock and reset ports.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 mem_req_i  input  1  access request from the load/store stage.
REQ-007 mem_addr_i  input  32  byte address.
REQ-008 mem_byte_en_i  input  2  size: 2'b00 byte, 2'b01 halfword, 2'b10 reserved, 2'b11 word.
REQ-009 mem_wr_i  input  1  1 = store, 0 = load.
REQ-010 mem_wr_data_i  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 mem_rd_data_o  output  32  load data, right-aligned, upper unused bits zero.
REQ-012 mem_ready_o  output  1  one-cycle completion pulse; the core stalls until it is seen.
REQ-013 mem_err_o  output  1  misaligned-access flag, valid with mem_ready_o.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 IDLE with mem_req_i=1 SHALL latch addr, size, wr and wr_data, load the wait counter with WAIT_CYCLES, and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP in the cycle after it reaches 1.
REQ-017 RESP SHALL assert mem_ready_o for exactly one cycle and return to IDLE; a request is accepted no earlier than the cycle after RESP.
REQ-018 Latency: a request accepted in cycle T SHALL see mem_ready_o high in cycle T+1+WAIT_CYCLES.
REQ-019 Input changes after acceptance SHALL be ignored; latched values govern the access.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap.
REQ-021 Misaligned cases: halfword with addr[0]=1, or word/reserved with addr[1:0]!=0; these SHALL give mem_err_o=1 and mem_rd_data_o=0 in RESP, with no array write.
REQ-022 Reserved size SHALL behave exactly as word.
REQ-023 Byte load SHALL return word[8*addr[1:0]+7 -: 8] in [7:0], with zeros above.
REQ-024 Halfword load SHALL return word[16*addr[1]+15 -: 16] in [15:0], with zeros above.
REQ-025 A store SHALL read-modify-write the array at the RESP clock edge, updating only the addressed byte/halfword lanes.
REQ-026 A store SHALL leave mem_rd_data_o unchanged.
REQ-027 mem_rd_data_o SHALL hold its value until the next load RESP.
REQ-028 mem_ready_o and mem_err_o SHALL be 0 outside RESP.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset_n=0 at a clock edge SHALL force state IDLE, counter 0, mem_ready_o=0, mem_err_o=0, mem_rd_data_o=0.
REQ-031 Reset during WAIT or RESP SHALL abort the access; a pending store SHALL NOT be written.
REQ-032 Array contents SHALL NOT be cleared by reset.

Verification
REQ-033 WAIT_CYCLES=1: word store 0xDEADBEEF to 0x100, then word load 0x100 -> ready 2 cycles after each accept, rd_data 0xDEADBEEF, err 0.
REQ-034 After REQ-033, byte store 0x55 to 0x102 then word load 0x100 -> 0xDE55BEEF; byte load 0x103 -> 0x000000DE.
REQ-035 Halfword load at 0x101 -> err=1, rd_data 0; a halfword store at 0x101 leaves word 0x100 unchanged.
REQ-036 WAIT_CYCLES=0, with mem_req_i held high continuously -> ready pulses every 2 cycles and never on consecutive cycles.
REQ-037 Store accepted, then reset_n=0 in WAIT -> ready never asserts and a later load returns the old word.
REQ-038 DEPTH_WORDS=1024: store 0x12345678 to 0x1000, then load 0x0000 -> 0x12345678 (address wrap).
